// File: rtl/instr_fetch.sv
// Instruction fetch stage: one single-beat request per instruction, response latch, stall/flush/timeout.
// Optional misaligned-pc fault when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_next,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              fetch_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StValid,
        StDrain,
        StErr
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] word_addr;
    logic              misaligned;
    logic              timed_out;

    assign word_addr = pc & ~ADDR_W'(3);
    assign timed_out = (cnt_q == CntW'(TIMEOUT));

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // The pc advanced by pc_next only becomes visible in the REQ cycle itself, so the
    // address is taken straight from pc there and from the held copy everywhere else.
    assign imem_req  = (state_q == StReq) && !misaligned;
    assign imem_addr = (state_q == StReq) ? word_addr : addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            pc_next     <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            pc_next <= 1'b0;
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    cnt_q  <= '0;
                    addr_q <= word_addr;
                    if (misaligned) begin
                        state_q   <= StErr;
                        fetch_err <= 1'b1;
                    end else if (flush) begin
                        state_q <= StDrain;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (flush) begin
                        state_q <= StDrain;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= addr_q;
                        instr_valid <= 1'b1;
                        pc_next     <= 1'b1;
                        state_q     <= StValid;
                    end else if (timed_out) begin
                        state_q   <= StErr;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StValid: begin
                    if (flush) begin
                        instr_valid <= 1'b0;
                        state_q     <= StIdle;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        state_q     <= StReq;
                    end
                end
                // Response still owed by memory; swallow it without advancing the pc.
                StDrain: begin
                    if (imem_ack) begin
                        state_q <= StIdle;
                    end else if (timed_out) begin
                        state_q   <= StErr;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StErr: state_q <= StErr;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
